// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO register stage and its latency counter.
package md_pkg;

    // Multiply/divide op encodings as carried on mdOp / md_op
    localparam logic [3:0] MD_DIV   = 4'd0;
    localparam logic [3:0] MD_DIVU  = 4'd1;
    localparam logic [3:0] MD_MULT  = 4'd2;
    localparam logic [3:0] MD_MULTU = 4'd3;

    // Default modelled latencies, in cycles from issue to HI/LO write
    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Codes 4..15 are reserved and never start an operation
    function automatic logic md_op_valid(input logic [3:0] op);
        return op < 4'd4;
    endfunction

    function automatic logic md_op_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// Pipeline-side bus of the HI/LO stage: issue, mthi/mtlo, mfhi/mflo stall.
interface hilo_unit_if;
    import md_pkg::*;

    logic        start;
    logic [3:0]  mdOp;
    logic [31:0] din1;
    logic [31:0] din2;
    logic        we_hi;
    logic        we_lo;
    logic [31:0] wdata;
    logic        rd_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    // Pipeline (EX/ID) side
    modport master (
        output start, mdOp, din1, din2, we_hi, we_lo, wdata, rd_req,
        input  hi, lo, busy, stall
    );

    // HI/LO stage side
    modport slave (
        input  start, mdOp, din1, din2, we_hi, we_lo, wdata, rd_req,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/hilo_unit_ctr.sv
// Loadable down-counter that measures the remaining latency of an op.
module md_latency_ctr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the counter parks at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/hilo_unit.sv
// HI/LO register stage: latches a mul/div request, holds the operands on
// the MulDiv inputs for the modelled latency, then captures its result.
module hilo_unit
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  bus,
    output logic [3:0]  md_op,
    output logic [31:0] md_din1,
    output logic [31:0] md_din2,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    md_state_e   state_q, state_d;
    logic [3:0]  md_op_q, md_op_d;
    logic [31:0] md_din1_q, md_din1_d;
    logic [31:0] md_din2_q, md_din2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic             issue;
    logic             busy;
    logic             stall;
    logic             cnt_zero;
    logic [CNT_W-1:0] lat_m1;

    assign issue = bus.start && md_op_valid(bus.mdOp);
    assign busy  = (state_q == RUN);
    assign stall = (bus.rd_req | bus.we_hi | bus.we_lo) & (busy | issue);

    // Counter reload value: latency minus one for the op being issued
    always_comb begin
        lat_m1 = CNT_W'(MUL_LAT - 1);
        if (md_op_is_div(bus.mdOp)) begin
            lat_m1 = CNT_W'(DIV_LAT - 1);
        end
    end

    md_latency_ctr #(
        .W (CNT_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (issue),
        .load_val (lat_m1),
        .en       (busy),
        .zero     (cnt_zero)
    );

    // Next state, operand latch and HI/LO update. A restart that lands on
    // the final RUN cycle suppresses the old result write.
    always_comb begin
        state_d   = state_q;
        md_op_d   = md_op_q;
        md_din1_d = md_din1_q;
        md_din2_d = md_din2_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (issue) begin
            state_d   = RUN;
            md_op_d   = bus.mdOp;
            md_din1_d = bus.din1;
            md_din2_d = bus.din2;
        end else if (busy && cnt_zero) begin
            state_d = IDLE;
            hi_d    = md_hi;
            lo_d    = md_lo;
        end

        // mthi/mtlo never collide with a result write: any write request
        // while busy is stalled
        if (!stall) begin
            if (bus.we_hi) hi_d = bus.wdata;
            if (bus.we_lo) lo_d = bus.wdata;
        end
    end

    // State, operand and architectural register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            md_op_q   <= '0;
            md_din1_q <= '0;
            md_din2_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            md_op_q   <= md_op_d;
            md_din1_q <= md_din1_d;
            md_din2_q <= md_din2_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md_op     = md_op_q;
    assign md_din1   = md_din1_q;
    assign md_din2   = md_din2_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy;
    assign bus.stall = stall;
endmodule
